// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type, frame constants and baud helper.
// UART_TX_PARITY_EN adds the PARITY state (8E1 framing); default is 8N1.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_t;

  function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                               input int unsigned bps);
    return clk_freq / bps;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Per-byte serializer: baud timing, data bit index and registered tx line.
// Under UART_TX_PARITY_EN it also drives the even-parity bit.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_CNT_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  tx_state_t  state,
  input  logic [7:0] byte_data,
  output logic       tx,
  output logic       bit_end,
  output logic       last_bit
);

  localparam int unsigned       CNT_W    = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);

  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic             tx_d;
  logic             tx_q;

  assign bit_end  = (baud_cnt == CNT_LAST);
  assign last_bit = (bit_idx == 3'(DATA_BITS - 1));
  assign tx       = tx_q;

  always_ff @(posedge clk) begin
    if (rst || state == IDLE || state == LOAD || bit_end) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state != DATA) begin
      bit_idx <= '0;
    end else if (bit_end) begin
      bit_idx <= bit_idx + 1'b1;
    end
  end

  always_comb begin
    tx_d = STOP_BIT;
    case (state)
      START:   tx_d = START_BIT;
      DATA:    tx_d = byte_data[bit_idx];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = ^byte_data;
`endif
      STOP:    tx_d = STOP_BIT;
      default: tx_d = STOP_BIT;
    endcase
  end

  // tx lags the state by one cycle uniformly, so all inter-bit timing is preserved
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q <= 1'b1;
    end else begin
      tx_q <= tx_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// FIFO-fed UART transmitter: reads one word, sends its bytes MSB-byte first.
// Parity framing selected by `define UART_TX_PARITY_EN.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned UART_BPS      = 9600,
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned FIFO_RD_WIDTH = 16,
  parameter int unsigned FIFO_RD_BYTE  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FIFO_RD_WIDTH-1:0] fifo_rd_data,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  output logic                     tx,
  output logic                     busy
);

  localparam int unsigned BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam int unsigned BYTE_W       = (FIFO_RD_BYTE > 1) ? $clog2(FIFO_RD_BYTE) : 1;

  tx_state_t                state;
  tx_state_t                next_state;
  logic [FIFO_RD_WIDTH-1:0] word;
  logic [BYTE_W-1:0]        byte_cnt;
  logic                     bit_end;
  logic                     last_bit;
  logic                     last_byte;

  assign last_byte = (byte_cnt == BYTE_W'(FIFO_RD_BYTE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!fifo_empty) next_state = LOAD;
      LOAD:    next_state = START;
      START:   if (bit_end) next_state = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:    if (bit_end && last_bit) next_state = PARITY;
      PARITY:  if (bit_end) next_state = STOP;
`else
      DATA:    if (bit_end && last_bit) next_state = STOP;
`endif
      STOP:    if (bit_end) next_state = last_byte ? IDLE : START;
      default: next_state = IDLE;
    endcase
  end

  // rst gates the request combinationally so no read is issued during reset
  always_comb begin
    fifo_rd_en = (state == IDLE) && !fifo_empty && !rst;
    busy       = (state != IDLE);
  end

  // The outgoing byte is always the top byte; the word shifts left after each stop bit
  always_ff @(posedge clk) begin
    if (rst) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (state == LOAD) begin
      word     <= fifo_rd_data;
      byte_cnt <= '0;
    end else if (state == STOP && bit_end && !last_byte) begin
      word     <= word << DATA_BITS;
      byte_cnt <= byte_cnt + 1'b1;
    end
  end

  uart_byte_tx #(
    .BAUD_CNT_MAX(BAUD_CNT_MAX)
  ) u_byte_tx (
    .clk      (clk),
    .rst      (rst),
    .state    (state),
    .byte_data(word[FIFO_RD_WIDTH-1 -: 8]),
    .tx       (tx),
    .bit_end  (bit_end),
    .last_bit (last_bit)
  );

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed self-checking bench for uart_transmitter at 16 clk cycles per bit.
module tb_uart_transmitter;

  localparam int BIT = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * BIT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] fifo_rd_data = '0;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic        tx;
  logic        busy;

  logic [15:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_cnt = 0;
  int bad_rd = 0;
  int cyc    = 0;
  int checks   = 0;
  int failures = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always #5 clk = ~clk;

  // FIFO model with one-cycle read latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (fifo_empty || rst) begin
        bad_rd <= bad_rd + 1;
      end else begin
        fifo_rd_data <= mem[rd_ptr % 16];
        rd_ptr       <= rd_ptr + 1;
      end
    end
  end

  uart_transmitter #(
    .UART_BPS     (1),
    .CLK_FREQ     (16),
    .FIFO_RD_WIDTH(16),
    .FIFO_RD_BYTE (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_rd_data(fifo_rd_data),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .tx          (tx),
    .busy        (busy)
  );

  task automatic push(input logic [15:0] w);
    mem[wr_ptr % 16] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // Receives one frame sampling once per negedge; ok=0 on timeout or malformed bits
  task automatic recv_byte(output logic [7:0] b, output logic par, output int t0,
                           output bit ok);
    int   n;
    logic first;
    logic val;
    ok = 1'b1; b = '0; par = 1'b0; t0 = 0; n = 0;
    while (tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    t0 = cyc;
    for (int i = 0; i < FRAME_BITS; i++) begin
      first = 1'bx;
      for (int j = 0; j < BIT; j++) begin
        if (!(i == 0 && j == 0)) @(negedge clk);
        val = tx;
        if (j == 0) first = val;
        else if (val !== first) ok = 1'b0;
      end
      if (i == 0 && first !== 1'b0) ok = 1'b0;
      if (i >= 1 && i <= 8) b[i-1] = first;
      if (FRAME_BITS == 11 && i == 9) par = first;
      if (i == FRAME_BITS - 1 && first !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_idle();
    int bad = 0;
    int r0  = rd_cnt;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_rd_en !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL idle_lines: got %0d bad cycles expected 0", bad); end
    checks++;
    if (rd_cnt !== r0) begin failures++; $display("FAIL idle_reads: got %0d expected %0d", rd_cnt, r0); end
  endtask

  task automatic test_single_word();
    logic [7:0] b; logic p; int t0, t1; bit ok;
    int r0 = rd_cnt;
    push(16'hA55A);
    #1;
    checks++;
    if (fifo_rd_en !== 1'b1) begin failures++; $display("FAIL single_rd_en: got %b expected 1", fifo_rd_en); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || fifo_rd_en !== 1'b0) begin
      failures++; $display("FAIL single_load: got busy=%b rd_en=%b expected busy=1 rd_en=0", busy, fifo_rd_en);
    end
    recv_byte(b, p, t0, ok);
    checks++;
    if (!ok || b !== 8'hA5) begin failures++; $display("FAIL single_byte0: got %h ok=%0d expected a5 ok=1", b, ok); end
    recv_byte(b, p, t1, ok);
    checks++;
    if (!ok || b !== 8'h5A) begin failures++; $display("FAIL single_byte1: got %h ok=%0d expected 5a ok=1", b, ok); end
    checks++;
    if (t1 - t0 !== FRAME) begin failures++; $display("FAIL single_gap: got %0d expected %0d", t1 - t0, FRAME); end
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end: got %b expected 0", busy); end
    checks++;
    if (rd_cnt - r0 !== 1) begin failures++; $display("FAIL single_reads: got %0d expected 1", rd_cnt - r0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [4];
    int         exp_d [4];
    logic [7:0] b; logic p; int t, tp; bit ok;
    int r0 = rd_cnt;
    exp_b = '{8'h12, 8'h34, 8'h56, 8'h78};
    exp_d = '{0, FRAME, FRAME + 2, FRAME};
    tp = 0;
    push(16'h1234);
    push(16'h5678);
    for (int i = 0; i < 4; i++) begin
      recv_byte(b, p, t, ok);
      checks++;
      if (!ok || b !== exp_b[i]) begin
        failures++; $display("FAIL b2b_byte%0d: got %h ok=%0d expected %h ok=1", i, b, ok, exp_b[i]);
      end
      if (i > 0) begin
        checks++;
        if (t - tp !== exp_d[i]) begin
          failures++; $display("FAIL b2b_gap%0d: got %0d expected %0d", i, t - tp, exp_d[i]);
        end
      end
      tp = t;
    end
    repeat (5) @(negedge clk);
    checks++;
    if (rd_cnt - r0 !== 2) begin failures++; $display("FAIL b2b_reads: got %0d expected 2", rd_cnt - r0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b; logic p; int t; bit ok;
    int n = 0;
    int bad = 0;
    int r0;
    push(16'h1234);
    while (tx !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (tx !== 1'b0) begin failures++; $display("FAIL mid_start_seen: got tx=%b expected 0", tx); end
    repeat (BIT + 40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
      failures++; $display("FAIL mid_reset: got tx=%b busy=%b rd_en=%b expected 1 0 0", tx, busy, fifo_rd_en);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    r0 = rd_cnt;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL mid_residual: got %0d bad cycles expected 0", bad); end
    checks++;
    if (rd_cnt !== r0) begin failures++; $display("FAIL mid_no_read: got %0d expected %0d", rd_cnt, r0); end
    rst = 1'b1;
    push(16'h5678);
    repeat (5) @(negedge clk);
    checks++;
    if (rd_cnt !== r0) begin failures++; $display("FAIL mid_read_in_reset: got %0d expected %0d", rd_cnt, r0); end
    rst = 1'b0;
    recv_byte(b, p, t, ok);
    checks++;
    if (!ok || b !== 8'h56) begin failures++; $display("FAIL mid_after_byte0: got %h ok=%0d expected 56 ok=1", b, ok); end
    recv_byte(b, p, t, ok);
    checks++;
    if (!ok || b !== 8'h78) begin failures++; $display("FAIL mid_after_byte1: got %h ok=%0d expected 78 ok=1", b, ok); end
    repeat (5) @(negedge clk);
    checks++;
    if (rd_cnt - r0 !== 1) begin failures++; $display("FAIL mid_after_reads: got %0d expected 1", rd_cnt - r0); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] b; logic p; int t0, t1; bit ok;
    push(16'h0703);
    recv_byte(b, p, t0, ok);
    checks++;
    if (!ok || b !== 8'h07 || p !== 1'b1) begin
      failures++; $display("FAIL parity_07: got %h p=%b ok=%0d expected 07 p=1 ok=1", b, p, ok);
    end
    recv_byte(b, p, t1, ok);
    checks++;
    if (!ok || b !== 8'h03 || p !== 1'b0) begin
      failures++; $display("FAIL parity_03: got %h p=%b ok=%0d expected 03 p=0 ok=1", b, p, ok);
    end
    checks++;
    if (t1 - t0 !== 11 * BIT) begin failures++; $display("FAIL parity_frame: got %0d expected %0d", t1 - t0, 11 * BIT); end
    repeat (5) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
    test_single_word();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    checks++;
    if (bad_rd !== 0) begin failures++; $display("FAIL illegal_reads: got %0d expected 0", bad_rd); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 The block SHALL have parameter UART_BPS, default 9600, serial baud rate.
REQ-002 The block SHALL have parameter CLK_FREQ, default 50_000_000, clk frequency in Hz.
REQ-003 The block SHALL have parameter FIFO_RD_WIDTH, default 16, read-FIFO data width.
REQ-004 The block SHALL have parameter FIFO_RD_BYTE, default 2, bytes per FIFO word; FIFO_RD_WIDTH SHALL equal 8*FIFO_RD_BYTE.
REQ-005 The block SHALL have port clk, input, 1, the single clock, synchronous with the read-FIFO read port.
REQ-006 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port fifo_rd_data, input, FIFO_RD_WIDTH, read-FIFO output word.
REQ-008 The block SHALL have port fifo_empty, input, 1, read-FIFO empty flag.
REQ-009 The block SHALL have port fifo_rd_en, output, 1, one-cycle read-FIFO read request.
REQ-010 The block SHALL have port tx, output, 1, RS232 serial line.
REQ-011 The block SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-012 The block SHALL use 8N1 framing: one start bit (0), 8 data bits sent LSB first, one stop bit (1); tx SHALL be 1 when idle.
REQ-013 Bit period SHALL be BAUD_CNT_MAX = CLK_FREQ/UART_BPS clk cycles (integer truncation); the baud counter SHALL be clog2(BAUD_CNT_MAX) bits wide and SHALL count 0..BAUD_CNT_MAX-1, then wrap.
REQ-014 The FSM states SHALL be IDLE, LOAD, START, DATA, STOP.
REQ-015 In IDLE with fifo_empty=0, fifo_rd_en SHALL be 1 for exactly one cycle, then the FSM SHALL go to LOAD; with fifo_empty=1 the FSM SHALL stay in IDLE and fifo_rd_en SHALL be 0.
REQ-016 The FIFO SHALL have one-cycle read latency (standard mode): in LOAD, fifo_rd_data SHALL be captured into the shift word, the byte counter SHALL be cleared, and the FSM SHALL go to START on the next cycle.
REQ-017 Bytes SHALL be sent most-significant byte first, i.e. fifo_rd_data[FIFO_RD_WIDTH-1 -: 8] first, matching the packing order of uart_receiver.
REQ-018 START SHALL drive tx=0 for one bit period, DATA SHALL drive 8 bit periods, and STOP SHALL drive tx=1 for one bit period.
REQ-019 At the end of STOP, if bytes remain in the word, the FSM SHALL enter START on the next cycle with no gap; after the last byte it SHALL enter IDLE.
REQ-020 The gap between the last stop bit of one word and the start bit of the next word SHALL be exactly 2 cycles (IDLE, then LOAD).
REQ-021 fifo_rd_en SHALL never be asserted outside IDLE and SHALL never be asserted while fifo_empty=1.
REQ-022 fifo_empty changes during a frame SHALL be ignored until the FSM returns to IDLE.
REQ-023 tx SHALL be registered and glitch-free.

Reset
REQ-024 When rst=1, on the next clk edge: FSM=IDLE, tx=1, busy=0, fifo_rd_en=0, and all counters and the shift word cleared.
REQ-025 Reset mid-frame SHALL abort the frame, discard the captured word, and drive tx=1 on the following cycle; no FIFO read SHALL occur while rst=1.

Configuration
REQ-026 With UART_TX_PARITY_EN defined, an even-parity bit SHALL be inserted between the data bits and the stop bit (state PARITY, one bit period), giving 8E1 framing.
REQ-027 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent and framing SHALL be 8N1.

Structure
REQ-028 The shared package uart_pkg SHALL hold the FSM state typedef, the frame constants (data bits = 8, start = 0, stop = 1), and the baud count helper.
REQ-029 The per-byte serializer (START/DATA/PARITY/STOP timing) SHALL be implemented as sub-module uart_byte_tx; uart_transmitter SHALL own the FIFO handshake and byte sequencing.

Verification
REQ-030 Use CLK_FREQ=16 and UART_BPS=1 (16 cycles/bit). FIFO holds 0xA55A; pulse empty low -> one rd_en, then frames 0xA5 and 0x5A with 0 gap between them, LSB first, 160 cycles each.
REQ-031 FIFO holds 2 words 0x1234, 0x5678 -> bytes 12,34,56,78 in order, with exactly 2 idle cycles between the 0x34 stop bit and the 0x56 start bit.
REQ-032 fifo_empty=1 throughout -> tx stays 1, fifo_rd_en stays 0, and busy stays 0 for 1000 cycles.
REQ-033 rst asserted in the DATA state of byte 0x12 -> tx=1 next cycle; after release, no residual bits are sent and no extra FIFO read occurs until fifo_empty=0.
REQ-034 With UART_TX_PARITY_EN, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; each frame is 11 bit periods.
